// File: rtl/if_id_skid_reg_pkg.sv
// Items shared by every pipeline stage register (IF/ID, ID/EX, EX/MEM):
// state encoding, default bubble word and a small handshake helper.
package if_id_skid_reg_pkg;

  // Stage-register states; the encoding is also the occupancy count.
  typedef enum logic [1:0] {
    PR_EMPTY = 2'd0,
    PR_BUSY  = 2'd1,
    PR_FULL  = 2'd2
  } pr_state_e;

  // Default instruction presented to the next stage when nothing is held.
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Upstream may push whenever the skid slot is still free.
  function automatic logic pr_can_accept(input pr_state_e st);
    return (st != PR_FULL);
  endfunction

endpackage

// File: rtl/if_id_skid_reg_pipe_entry.sv
// One pipeline storage slot: data plus valid flag, with synchronous load
// and clear. Clear wins over load and returns the data to CLR_VAL so the
// slot presents a clean bubble whenever it is empty.
module pipe_entry #(
  parameter int           W       = 64,
  parameter logic [W-1:0] CLR_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Slot storage: async reset, clear has priority over load, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      data_r  <= CLR_VAL;
    end else if (clear) begin
      valid_r <= 1'b0;
      data_r  <= CLR_VAL;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= d;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign q     = data_r;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake and a two-entry skid
// buffer. The main entry drives the decode stage directly; the skid entry
// absorbs the word accepted in the cycle decode stalled, so in_ready can be
// a registered signal without ever dropping a fetched word.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int                 INSTR_W  = 32,
  parameter int                 PC_W     = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(DEFAULT_NOP_WORD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         occupancy
);

  localparam int              DW     = INSTR_W + PC_W;
  localparam logic [DW-1:0]   BUBBLE = {NOP_WORD, {PC_W{1'b0}}};

  pr_state_e       state_r;
  pr_state_e       state_s;
  logic            in_ready_r;
  logic            accept_s;
  logic            consume_s;
  logic            main_load_s;
  logic            main_clr_s;
  logic [DW-1:0]   main_d_s;
  logic            skid_load_s;
  logic            skid_clr_s;
  logic            main_v_s;
  logic [DW-1:0]   main_q_s;
  logic            skid_v_s;
  logic [DW-1:0]   skid_q_s;
  logic [DW-1:0]   in_word_s;

  assign in_word_s = {in_instr, in_pc};
  assign accept_s  = in_valid & in_ready_r;
  assign consume_s = main_v_s & out_ready;

  // Next-state and slot steering; flush overrides any same-cycle transfer.
  always_comb begin
    state_s     = state_r;
    main_load_s = 1'b0;
    main_clr_s  = 1'b0;
    main_d_s    = in_word_s;
    skid_load_s = 1'b0;
    skid_clr_s  = 1'b0;
    if (flush) begin
      state_s    = PR_EMPTY;
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else begin
      case (state_r)
        PR_EMPTY: begin
          if (accept_s) begin
            state_s     = PR_BUSY;
            main_load_s = 1'b1;
          end else begin
            state_s = PR_EMPTY;
          end
        end
        PR_BUSY: begin
          if (accept_s && !consume_s) begin
            state_s     = PR_FULL;
            skid_load_s = 1'b1;
          end else if (accept_s && consume_s) begin
            state_s     = PR_BUSY;
            main_load_s = 1'b1;
          end else if (consume_s) begin
            state_s    = PR_EMPTY;
            main_clr_s = 1'b1;
          end else begin
            state_s = PR_BUSY;
          end
        end
        PR_FULL: begin
          // in_ready is low here, so only the skid word can move forward.
          if (consume_s) begin
            state_s     = PR_BUSY;
            main_load_s = 1'b1;
            main_d_s    = skid_q_s;
            skid_clr_s  = 1'b1;
          end else begin
            state_s = PR_FULL;
          end
        end
        default: begin
          state_s    = PR_EMPTY;
          main_clr_s = 1'b1;
          skid_clr_s = 1'b1;
        end
      endcase
    end
  end

  // FSM state and registered upstream ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= PR_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      in_ready_r <= pr_can_accept(state_s);
    end
  end

  pipe_entry #(.W(DW), .CLR_VAL(BUBBLE)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load_s),
    .clear (main_clr_s),
    .d     (main_d_s),
    .valid (main_v_s),
    .q     (main_q_s)
  );

  pipe_entry #(.W(DW), .CLR_VAL(BUBBLE)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load_s),
    .clear (skid_clr_s),
    .d     (in_word_s),
    .valid (skid_v_s),
    .q     (skid_q_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = main_v_s;
  assign out_instr = main_q_s[DW-1:PC_W];
  assign out_pc    = main_q_s[PC_W-1:0];
  assign occupancy = state_r;

  logic unused_s;
  assign unused_s = skid_v_s;

endmodule
